// File: rtl/fpro_bus_arbiter_pkg.sv
// Shared types and widths for the FPro MMIO bus arbiter.
// Imported by the interface, the grant selector and the top.
package fpro_arb_pkg;

   localparam int FP_ADDR_W = 21;
   localparam int FP_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      ACK  = 2'd2
   } arb_state_t;

   typedef logic mst_idx_t;

endpackage

// File: rtl/fpro_bus_arbiter_if.sv
// Bundle of both master request ports and the FPro MMIO bus.
// slave: the arbiter's view; master: requesters plus mmio side.
interface fpro_bus_arbiter_if
   import fpro_arb_pkg::*;
#(
   parameter int ADDR_W = FP_ADDR_W,
   parameter int DATA_W = FP_DATA_W
);

   logic              m0_req;
   logic              m0_wr;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wr_data;
   logic [DATA_W-1:0] m0_rd_data;
   logic              m0_ack;

   logic              m1_req;
   logic              m1_wr;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wr_data;
   logic [DATA_W-1:0] m1_rd_data;
   logic              m1_ack;

   logic              fp_mmio_cs;
   logic              fp_wr;
   logic              fp_rd;
   logic [ADDR_W-1:0] fp_addr;
   logic [DATA_W-1:0] fp_wr_data;
   logic [DATA_W-1:0] fp_rd_data;
   logic              owner;

   modport slave (
      input  m0_req, m0_wr, m0_addr, m0_wr_data,
      output m0_rd_data, m0_ack,
      input  m1_req, m1_wr, m1_addr, m1_wr_data,
      output m1_rd_data, m1_ack,
      output fp_mmio_cs, fp_wr, fp_rd,
      output fp_addr, fp_wr_data,
      input  fp_rd_data,
      output owner
   );

   modport master (
      output m0_req, m0_wr, m0_addr, m0_wr_data,
      input  m0_rd_data, m0_ack,
      output m1_req, m1_wr, m1_addr, m1_wr_data,
      input  m1_rd_data, m1_ack,
      input  fp_mmio_cs, fp_wr, fp_rd,
      input  fp_addr, fp_wr_data,
      output fp_rd_data,
      input  owner
   );

endinterface

// File: rtl/fpro_bus_arbiter_rr_arbiter_2.sv
// Two-way grant selector: round-robin on ~last_grant,
// or m0-wins-ties when FIXED_PRIO is set.
module rr_arbiter_2
   import fpro_arb_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic [1:0] req,
   input  mst_idx_t   last_grant,
   output logic       gnt_vld,
   output mst_idx_t   gnt_idx
);

   // Winner of the current request pair.
   always_comb begin
      gnt_vld = |req;
      gnt_idx = 1'b0;
      case (req)
         2'b11:   gnt_idx = FIXED_PRIO ? 1'b0 : ~last_grant;
         2'b10:   gnt_idx = 1'b1;
         default: gnt_idx = 1'b0;
      endcase
   end

endmodule

// File: rtl/fpro_bus_arbiter.sv
// Shares one FPro MMIO bus between two masters.
// Three-cycle IDLE/XFER/ACK sequence, all outputs registered.
module fpro_bus_arbiter
   import fpro_arb_pkg::*;
#(
   parameter int ADDR_W     = FP_ADDR_W,
   parameter int DATA_W     = FP_DATA_W,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   fpro_bus_arbiter_if.slave  bus
);

   arb_state_t        state_q, state_d;
   mst_idx_t          owner_q, owner_d;
   mst_idx_t          last_q, last_d;
   logic              cs_q, cs_d;
   logic              wr_q, wr_d;
   logic              rd_q, rd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic [DATA_W-1:0] rd0_q, rd0_d;
   logic [DATA_W-1:0] rd1_q, rd1_d;

   logic              gnt_vld;
   mst_idx_t          gnt_idx;
   logic              win_wr;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   rr_arbiter_2 #(
      .FIXED_PRIO (FIXED_PRIO)
   ) u_sel (
      .req        ({bus.m1_req, bus.m0_req}),
      .last_grant (last_q),
      .gnt_vld    (gnt_vld),
      .gnt_idx    (gnt_idx)
   );

   assign win_wr    = gnt_idx ? bus.m1_wr      : bus.m0_wr;
   assign win_addr  = gnt_idx ? bus.m1_addr    : bus.m0_addr;
   assign win_wdata = gnt_idx ? bus.m1_wr_data : bus.m0_wr_data;

   // Next-state and next-output computation for the bus sequencer.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cs_d    = cs_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      rd0_d   = rd0_q;
      rd1_d   = rd1_q;
      unique case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               state_d = XFER;
               owner_d = gnt_idx;
               cs_d    = 1'b1;
               wr_d    = win_wr;
               rd_d    = ~win_wr;
               addr_d  = win_addr;
               wdata_d = win_wdata;
            end
         end
         XFER: begin
            state_d = ACK;
            cs_d    = 1'b0;
            wr_d    = 1'b0;
            rd_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
            if (owner_q) ack1_d = 1'b1;
            else         ack0_d = 1'b1;
            if (rd_q && owner_q)  rd1_d = bus.fp_rd_data;
            if (rd_q && !owner_q) rd0_d = bus.fp_rd_data;
         end
         ACK: begin
            state_d = IDLE;
            last_d  = owner_q;
         end
         default: begin
            state_d = IDLE;
            cs_d    = 1'b0;
            wr_d    = 1'b0;
            rd_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
         end
      endcase
   end

   // State and output registers; reset drops bus strobes at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         cs_q    <= 1'b0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         rd0_q   <= '0;
         rd1_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cs_q    <= cs_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
      end
   end

   assign bus.fp_mmio_cs = cs_q;
   assign bus.fp_wr      = wr_q;
   assign bus.fp_rd      = rd_q;
   assign bus.fp_addr    = addr_q;
   assign bus.fp_wr_data = wdata_q;
   assign bus.m0_ack     = ack0_q;
   assign bus.m1_ack     = ack1_q;
   assign bus.m0_rd_data = rd0_q;
   assign bus.m1_rd_data = rd1_q;
   assign bus.owner      = owner_q;

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// Directed bench for fpro_bus_arbiter: one round-robin instance
// and one fixed-priority instance, each with a small slave model.
module tb_fpro_bus_arbiter;
   import fpro_arb_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a;
   logic        rst_b;
   logic        ovr_a;
   logic [31:0] ovr_val;
   int          checks = 0;
   int          errors = 0;

   fpro_bus_arbiter_if ia ();
   fpro_bus_arbiter_if ib ();

   // Slave returns the override word, else the zero-extended address.
   assign ia.fp_rd_data = ovr_a ? ovr_val : 32'(ia.fp_addr);
   assign ib.fp_rd_data = 32'(ib.fp_addr);

   fpro_bus_arbiter #(.FIXED_PRIO(1'b0)) dut_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (ia)
   );

   fpro_bus_arbiter #(.FIXED_PRIO(1'b1)) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (ib)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_a = 1'b1;
      rst_b = 1'b1;
      ovr_a = 1'b0;
      ovr_val = 32'h0;
      ia.m0_req = 0; ia.m0_wr = 0; ia.m0_addr = '0; ia.m0_wr_data = '0;
      ia.m1_req = 0; ia.m1_wr = 0; ia.m1_addr = '0; ia.m1_wr_data = '0;
      ib.m0_req = 0; ib.m0_wr = 0; ib.m0_addr = '0; ib.m0_wr_data = '0;
      ib.m1_req = 0; ib.m1_wr = 0; ib.m1_addr = '0; ib.m1_wr_data = '0;
      tick;
      tick;
      rst_a = 1'b0;
      rst_b = 1'b0;
      tick;
      checks++;
      if ({ia.fp_mmio_cs, ia.fp_wr, ia.fp_rd} !== 3'b000) begin
         errors++;
         $display("FAIL reset_strobes: got %b want 000",
                  {ia.fp_mmio_cs, ia.fp_wr, ia.fp_rd});
      end
      checks++;
      if (ia.fp_addr !== 21'h0 || ia.fp_wr_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_bus: addr %h data %h want 0", ia.fp_addr, ia.fp_wr_data);
      end
      checks++;
      if ({ia.m0_ack, ia.m1_ack, ia.owner} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ack_owner: got %b want 000",
                  {ia.m0_ack, ia.m1_ack, ia.owner});
      end
      checks++;
      if (ia.m0_rd_data !== 32'h0 || ia.m1_rd_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_rd_data: m0 %h m1 %h want 0", ia.m0_rd_data, ia.m1_rd_data);
      end
      checks++;
      if ({ib.fp_mmio_cs, ib.m0_ack, ib.m1_ack, ib.owner} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_b: got %b want 0000",
                  {ib.fp_mmio_cs, ib.m0_ack, ib.m1_ack, ib.owner});
      end
   endtask

   task automatic test_m0_read;
      ovr_a = 1'b1;
      ovr_val = 32'hDEADBEEF;
      ia.m0_wr = 1'b0;
      ia.m0_addr = 21'h00010;
      ia.m0_req = 1'b1;
      tick;
      checks++;
      if ({ia.fp_mmio_cs, ia.fp_rd, ia.fp_wr} !== 3'b110) begin
         errors++;
         $display("FAIL rd_strobe: cs/rd/wr %b want 110",
                  {ia.fp_mmio_cs, ia.fp_rd, ia.fp_wr});
      end
      checks++;
      if (ia.fp_addr !== 21'h00010) begin
         errors++;
         $display("FAIL rd_addr: got %h want 00010", ia.fp_addr);
      end
      checks++;
      if ({ia.m0_ack, ia.m1_ack} !== 2'b00) begin
         errors++;
         $display("FAIL rd_early_ack: got %b want 00", {ia.m0_ack, ia.m1_ack});
      end
      tick;
      checks++;
      if ({ia.m0_ack, ia.m1_ack} !== 2'b10) begin
         errors++;
         $display("FAIL rd_ack: got %b want 10", {ia.m0_ack, ia.m1_ack});
      end
      checks++;
      if ({ia.fp_mmio_cs, ia.fp_rd, ia.fp_wr} !== 3'b000) begin
         errors++;
         $display("FAIL rd_bus_idle: got %b want 000",
                  {ia.fp_mmio_cs, ia.fp_rd, ia.fp_wr});
      end
      checks++;
      if (ia.m0_rd_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd_data_m0: got %h want DEADBEEF", ia.m0_rd_data);
      end
      checks++;
      if (ia.m1_rd_data !== 32'h0) begin
         errors++;
         $display("FAIL rd_m1_untouched: got %h want 0", ia.m1_rd_data);
      end
      ia.m0_req = 1'b0;
      tick;
      checks++;
      if ({ia.m0_ack, ia.m1_ack} !== 2'b00) begin
         errors++;
         $display("FAIL rd_ack_pulse: got %b want 00", {ia.m0_ack, ia.m1_ack});
      end
      ovr_a = 1'b0;
   endtask

   task automatic test_m1_write;
      ia.m1_wr = 1'b1;
      ia.m1_addr = 21'h1F000;
      ia.m1_wr_data = 32'h0000_00A5;
      ia.m1_req = 1'b1;
      tick;
      checks++;
      if ({ia.fp_mmio_cs, ia.fp_rd, ia.fp_wr} !== 3'b101) begin
         errors++;
         $display("FAIL wr_strobe: cs/rd/wr %b want 101",
                  {ia.fp_mmio_cs, ia.fp_rd, ia.fp_wr});
      end
      checks++;
      if (ia.fp_addr !== 21'h1F000 || ia.fp_wr_data !== 32'hA5) begin
         errors++;
         $display("FAIL wr_bus: addr %h data %h want 1F000 000000A5",
                  ia.fp_addr, ia.fp_wr_data);
      end
      checks++;
      if (ia.owner !== 1'b1) begin
         errors++;
         $display("FAIL wr_owner: got %b want 1", ia.owner);
      end
      tick;
      checks++;
      if ({ia.m0_ack, ia.m1_ack} !== 2'b01) begin
         errors++;
         $display("FAIL wr_ack: got %b want 01", {ia.m0_ack, ia.m1_ack});
      end
      checks++;
      if (ia.m1_rd_data !== 32'h0 || ia.m0_rd_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL wr_rd_hold: m0 %h m1 %h want DEADBEEF 0",
                  ia.m0_rd_data, ia.m1_rd_data);
      end
      checks++;
      if (ia.fp_wr_data !== 32'h0 || ia.fp_addr !== 21'h0) begin
         errors++;
         $display("FAIL wr_bus_clear: addr %h data %h want 0", ia.fp_addr, ia.fp_wr_data);
      end
      ia.m1_req = 1'b0;
      tick;
   endtask

   task automatic test_round_robin;
      int acks = 0;
      int strobes = 0;
      int cyc = 0;
      int last_cyc = -1;
      ia.m0_wr = 1'b1; ia.m0_addr = 21'h00100; ia.m0_wr_data = 32'h11;
      ia.m1_wr = 1'b1; ia.m1_addr = 21'h00200; ia.m1_wr_data = 32'h22;
      ia.m0_req = 1'b1;
      ia.m1_req = 1'b1;
      while (acks < 6 && cyc < 40) begin
         tick;
         cyc++;
         if (ia.fp_mmio_cs === 1'b1) strobes++;
         checks++;
         if ((ia.m0_ack & ia.m1_ack) !== 1'b0) begin
            errors++;
            $display("FAIL rr_exclusive: both acks high at cycle %0d", cyc);
         end
         if (ia.m0_ack === 1'b1 || ia.m1_ack === 1'b1) begin
            checks++;
            if (ia.m1_ack !== acks[0]) begin
               errors++;
               $display("FAIL rr_order: ack %0d m1_ack %b want %b", acks, ia.m1_ack, acks[0]);
            end
            if (last_cyc >= 0) begin
               checks++;
               if (cyc - last_cyc != 3) begin
                  errors++;
                  $display("FAIL rr_spacing: gap %0d want 3", cyc - last_cyc);
               end
            end
            last_cyc = cyc;
            acks++;
         end
      end
      ia.m0_req = 1'b0;
      ia.m1_req = 1'b0;
      checks++;
      if (acks != 6) begin
         errors++;
         $display("FAIL rr_count: got %0d acks want 6", acks);
      end
      checks++;
      if (strobes != 6) begin
         errors++;
         $display("FAIL rr_strobes: got %0d strobes want 6", strobes);
      end
      tick;
   endtask

   task automatic test_fixed_prio;
      int acks = 0;
      int cyc = 0;
      int wait_cyc = 0;
      bit got1 = 1'b0;
      ib.m0_wr = 1'b1; ib.m0_addr = 21'h00300; ib.m0_wr_data = 32'h33;
      ib.m1_wr = 1'b1; ib.m1_addr = 21'h00400; ib.m1_wr_data = 32'h44;
      ib.m0_req = 1'b1;
      ib.m1_req = 1'b1;
      while (acks < 6 && cyc < 40) begin
         tick;
         cyc++;
         if (ib.m0_ack === 1'b1 || ib.m1_ack === 1'b1) begin
            checks++;
            if ({ib.m0_ack, ib.m1_ack} !== 2'b10) begin
               errors++;
               $display("FAIL fp_winner: ack %0d got %b want 10", acks,
                        {ib.m0_ack, ib.m1_ack});
            end
            acks++;
         end
      end
      checks++;
      if (acks != 6) begin
         errors++;
         $display("FAIL fp_count: got %0d acks want 6", acks);
      end
      ib.m0_req = 1'b0;
      while (!got1 && wait_cyc < 10) begin
         tick;
         wait_cyc++;
         checks++;
         if (ib.m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL fp_m0_extra: m0_ack %b after drop want 0", ib.m0_ack);
         end
         if (ib.m1_ack === 1'b1) got1 = 1'b1;
      end
      checks++;
      if (!got1 || wait_cyc != 3) begin
         errors++;
         $display("FAIL fp_m1_serve: got1 %b after %0d cycles want 1 after 3", got1, wait_cyc);
      end
      ib.m1_req = 1'b0;
      tick;
   endtask

   task automatic test_reset_mid;
      ia.m1_wr = 1'b1;
      ia.m1_addr = 21'h00ABC;
      ia.m1_wr_data = 32'h55;
      ia.m1_req = 1'b1;
      tick;
      checks++;
      if (ia.fp_mmio_cs !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_cs: got %b want 1", ia.fp_mmio_cs);
      end
      #2;
      rst_a = 1'b1;
      #1;
      checks++;
      if ({ia.fp_mmio_cs, ia.fp_wr, ia.fp_rd} !== 3'b000) begin
         errors++;
         $display("FAIL rst_async_drop: got %b want 000",
                  {ia.fp_mmio_cs, ia.fp_wr, ia.fp_rd});
      end
      tick;
      checks++;
      if ({ia.m0_ack, ia.m1_ack, ia.fp_mmio_cs} !== 3'b000) begin
         errors++;
         $display("FAIL rst_no_ack: got %b want 000",
                  {ia.m0_ack, ia.m1_ack, ia.fp_mmio_cs});
      end
      checks++;
      if (ia.m0_rd_data !== 32'h0) begin
         errors++;
         $display("FAIL rst_rd_clear: got %h want 0", ia.m0_rd_data);
      end
      rst_a = 1'b0;
      tick;
      checks++;
      if ({ia.fp_mmio_cs, ia.fp_rd, ia.fp_wr} !== 3'b101 ||
          ia.fp_addr !== 21'h00ABC || ia.fp_wr_data !== 32'h55) begin
         errors++;
         $display("FAIL rst_resume_bus: cs/rd/wr %b addr %h data %h want 101 00ABC 00000055",
                  {ia.fp_mmio_cs, ia.fp_rd, ia.fp_wr}, ia.fp_addr, ia.fp_wr_data);
      end
      tick;
      checks++;
      if ({ia.m0_ack, ia.m1_ack} !== 2'b01) begin
         errors++;
         $display("FAIL rst_resume_ack: got %b want 01", {ia.m0_ack, ia.m1_ack});
      end
      ia.m1_req = 1'b0;
      tick;
   endtask

   task automatic test_read_hold;
      ia.m0_wr = 1'b0;
      ia.m0_addr = 21'h01234;
      ia.m0_req = 1'b1;
      tick;
      tick;
      checks++;
      if (ia.m0_ack !== 1'b1 || ia.m0_rd_data !== 32'h1234) begin
         errors++;
         $display("FAIL hold_m0_read: ack %b data %h want 1 00001234", ia.m0_ack, ia.m0_rd_data);
      end
      ia.m0_req = 1'b0;
      tick;
      ia.m1_wr = 1'b0;
      ia.m1_addr = 21'h05678;
      ia.m1_req = 1'b1;
      tick;
      tick;
      checks++;
      if (ia.m1_ack !== 1'b1 || ia.m1_rd_data !== 32'h5678) begin
         errors++;
         $display("FAIL hold_m1_read: ack %b data %h want 1 00005678", ia.m1_ack, ia.m1_rd_data);
      end
      checks++;
      if (ia.m0_rd_data !== 32'h1234) begin
         errors++;
         $display("FAIL hold_m0_after_m1: got %h want 00001234", ia.m0_rd_data);
      end
      ia.m1_req = 1'b0;
      tick;
      ia.m0_wr = 1'b1;
      ia.m0_addr = 21'h00777;
      ia.m0_wr_data = 32'hFFFF;
      ia.m0_req = 1'b1;
      tick;
      tick;
      checks++;
      if (ia.m0_ack !== 1'b1 || ia.m0_rd_data !== 32'h1234) begin
         errors++;
         $display("FAIL hold_m0_after_wr: ack %b data %h want 1 00001234",
                  ia.m0_ack, ia.m0_rd_data);
      end
      ia.m0_req = 1'b0;
      tick;
   endtask

   initial begin
      test_reset;
      test_m0_read;
      test_m1_write;
      test_round_robin;
      test_fixed_prio;
      test_reset_mid;
      test_read_hold;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
